// File: rtl/aes128_package.sv
// rtl/aes128_package.sv - shared types and constants for the xorshift random source
//
// Purpose: default xorshift128 seed words, the per-core state record and the
// random-source FSM encoding. No ports.
package aes128_package;

  // Marsaglia's reference seed, substituted for an all-zero core seed
  // (an all-zero xorshift state never leaves zero).
  localparam logic [31:0] XS_SEED_X = 32'd123456789;
  localparam logic [31:0] XS_SEED_Y = 32'd362436069;
  localparam logic [31:0] XS_SEED_Z = 32'd521288629;
  localparam logic [31:0] XS_SEED_W = 32'd88675123;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] w;
  } xs_state_t;

  typedef enum logic [1:0] {
    RS_SEED   = 2'd0,
    RS_WARMUP = 2'd1,
    RS_RUN    = 2'd2
  } rs_state_e;

endpackage

// File: rtl/xorshift128_core.sv
// rtl/xorshift128_core.sv - one xorshift128 generator with word-wise seed loading
//
// Purpose: holds one 4x32-bit xorshift128 state, loads it one word at a time,
// and advances it by one step when asked. out_next_w is the w of the next state.
// Ports:
//   in_clock      clock, rising edge
//   in_reset      synchronous active-high reset, clears the state
//   in_load       write in_load_word into the register chosen by in_load_idx
//   in_load_idx   0=x 1=y 2=z 3=w
//   in_load_word  seed word
//   in_fix_zero   seeding completes this cycle: replace an all-zero state by defaults
//   in_step       advance the generator one step
//   out_next_w    low OUT_W bits of the next w (the random output)
module xorshift128_core
  import aes128_package::*;
#(
  parameter int OUT_W = 32
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic             in_load,
  input  logic [1:0]       in_load_idx,
  input  logic [31:0]      in_load_word,
  input  logic             in_fix_zero,
  input  logic             in_step,
  output logic [OUT_W-1:0] out_next_w
);

  xs_state_t   r_state;
  xs_state_t   w_loaded;
  logic [31:0] w_t;
  logic [31:0] w_next_w;

  assign w_t         = r_state.x ^ (r_state.x << 11);
  assign w_next_w    = r_state.w ^ (r_state.w >> 19) ^ w_t ^ (w_t >> 8);
  assign out_next_w  = w_next_w[OUT_W-1:0];

  // State as it will be after this cycle's load; the zero check must include
  // a word arriving in the same cycle as the fix request.
  always_comb begin
    w_loaded = r_state;
    if (in_load) begin
      case (in_load_idx)
        2'd0:    w_loaded.x = in_load_word;
        2'd1:    w_loaded.y = in_load_word;
        2'd2:    w_loaded.z = in_load_word;
        default: w_loaded.w = in_load_word;
      endcase
    end
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      r_state <= '0;
    end else if (in_fix_zero && (w_loaded == '0)) begin
      r_state <= '{x: XS_SEED_X, y: XS_SEED_Y, z: XS_SEED_Z, w: XS_SEED_W};
    end else if (in_load) begin
      r_state <= w_loaded;
    end else if (in_step) begin
      r_state <= '{x: r_state.y, y: r_state.z, z: r_state.w, w: w_next_w};
    end
  end

endmodule

// File: rtl/xorshift_random_source.sv
// rtl/xorshift_random_source.sv - seeded multi-core xorshift128 random word source
//
// Purpose: seeds NUM_CORES xorshift128 cores word-serially, discards
// WARMUP_CYCLES steps, then streams OUT_BITS random bits per accepted transfer.
// Ports:
//   in_clock        clock, rising edge
//   in_reset        synchronous active-high reset, highest priority
//   in_seed         seed word
//   in_seed_valid   seed word present
//   out_seed_ready  block accepts a seed word (SEED state)
//   in_reseed       single-cycle request to return to seeding
//   out_random      random data, zero unless out_valid
//   out_valid       out_random valid (RUN state)
//   in_ready        consumer accepts out_random
module xorshift_random_source
  import aes128_package::*;
#(
  parameter int OUT_BITS      = 2,
  parameter int WARMUP_CYCLES = 16
) (
  input  logic                in_clock,
  input  logic                in_reset,
  input  logic [31:0]         in_seed,
  input  logic                in_seed_valid,
  output logic                out_seed_ready,
  input  logic                in_reseed,
  output logic [OUT_BITS-1:0] out_random,
  output logic                out_valid,
  input  logic                in_ready
);

  localparam int NUM_CORES = (OUT_BITS + 31) / 32;
  localparam int NUM_WORDS = 4 * NUM_CORES;
  localparam int SCW       = $clog2(NUM_WORDS);
  localparam int WCW       = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [SCW-1:0] LAST_WORD = SCW'(NUM_WORDS - 1);
  localparam logic [WCW-1:0] LAST_WARM = WCW'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);
  localparam rs_state_e SEED_DONE = (WARMUP_CYCLES > 0) ? RS_WARMUP : RS_RUN;

  rs_state_e          r_state;
  logic [SCW-1:0]     r_seed_cnt;
  logic [WCW-1:0]     r_warm_cnt;
  logic               w_seed_acc;
  logic               w_last_word;
  logic               w_step;
  logic [OUT_BITS-1:0] w_cores_w;

  assign out_seed_ready = (r_state == RS_SEED);
  assign out_valid      = (r_state == RS_RUN);

  // A reseed request discards any coinciding seed word and freezes the cores,
  // although a coinciding RUN transfer still counts as delivered.
  assign w_seed_acc  = (r_state == RS_SEED) && in_seed_valid && !in_reseed;
  assign w_last_word = (r_seed_cnt == LAST_WORD);
  assign w_step      = !in_reseed &&
                       ((r_state == RS_WARMUP) || ((r_state == RS_RUN) && in_ready));

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
    // The top core only contributes the bits left over above the full words.
    localparam int CW = (k == NUM_CORES - 1) ? OUT_BITS - 32 * k : 32;
    logic w_load;

    assign w_load = w_seed_acc && (int'(r_seed_cnt >> 2) == k);

    xorshift128_core #(
      .OUT_W(CW)
    ) u_core (
      .in_clock     (in_clock),
      .in_reset     (in_reset),
      .in_load      (w_load),
      .in_load_idx  (r_seed_cnt[1:0]),
      .in_load_word (in_seed),
      .in_fix_zero  (w_seed_acc && w_last_word),
      .in_step      (w_step),
      .out_next_w   (w_cores_w[32*k +: CW])
    );
  end

  assign out_random = out_valid ? w_cores_w : '0;

  always_ff @(posedge in_clock) begin
    if (in_reset || in_reseed) begin
      r_state    <= RS_SEED;
      r_seed_cnt <= '0;
      r_warm_cnt <= '0;
    end else begin
      case (r_state)
        RS_SEED: begin
          if (in_seed_valid) begin
            if (w_last_word) begin
              r_seed_cnt <= '0;
              r_warm_cnt <= '0;
              r_state    <= SEED_DONE;
            end else begin
              r_seed_cnt <= r_seed_cnt + SCW'(1);
            end
          end
        end
        RS_WARMUP: begin
          if (r_warm_cnt == LAST_WARM) begin
            r_warm_cnt <= '0;
            r_state    <= RS_RUN;
          end else begin
            r_warm_cnt <= r_warm_cnt + WCW'(1);
          end
        end
        RS_RUN: begin
          r_state <= RS_RUN;
        end
        default: begin
          r_state <= RS_SEED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xorshift_random_source.sv
// tb/tb_xorshift_random_source.sv - self-checking bench for xorshift_random_source
module tb_xorshift_random_source;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] seed;
  logic        seed_valid;
  logic        reseed;
  logic        ready;
  logic        sr0, v0, sr16, v16;
  logic [31:0] r0, r16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Same stimulus to both: one without warm-up, one with 16 warm-up steps.
  xorshift_random_source #(.OUT_BITS(32), .WARMUP_CYCLES(0)) dut0 (
    .in_clock(clk), .in_reset(rst), .in_seed(seed), .in_seed_valid(seed_valid),
    .out_seed_ready(sr0), .in_reseed(reseed), .out_random(r0), .out_valid(v0),
    .in_ready(ready));

  xorshift_random_source #(.OUT_BITS(32), .WARMUP_CYCLES(16)) dut16 (
    .in_clock(clk), .in_reset(rst), .in_seed(seed), .in_seed_valid(seed_valid),
    .out_seed_ready(sr16), .in_reseed(reseed), .out_random(r16), .out_valid(v16),
    .in_ready(ready));

  // Golden xorshift128 model, one instance per DUT.
  logic [31:0] mx[2], my[2], mz[2], mw[2];
  logic [31:0] q0[$], q16[$];

  function automatic logic [31:0] m_out(int d);
    logic [31:0] t;
    t = mx[d] ^ (mx[d] << 11);
    return mw[d] ^ (mw[d] >> 19) ^ t ^ (t >> 8);
  endfunction

  task automatic m_step(int d);
    logic [31:0] n;
    n = m_out(d);
    mx[d] = my[d]; my[d] = mz[d]; mz[d] = mw[d]; mw[d] = n;
  endtask

  task automatic m_seed(int d, input logic [31:0] a, b, c, e);
    if ((a | b | c | e) == 32'd0) begin
      mx[d] = 32'd123456789; my[d] = 32'd362436069;
      mz[d] = 32'd521288629; mw[d] = 32'd88675123;
    end else begin
      mx[d] = a; my[d] = b; mz[d] = c; mw[d] = e;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; seed_valid = 1'b0; reseed = 1'b0; ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Feed the first n of four words; the block must be in SEED for each one.
  task automatic feed_words(input logic [31:0] a, b, c, e, input int n);
    logic [31:0] ws[4];
    ws[0] = a; ws[1] = b; ws[2] = c; ws[3] = e;
    for (int i = 0; i < n; i++) begin
      seed = ws[i];
      seed_valid = 1'b1;
      check("seed_ready_while_seeding", {31'd0, sr0}, 32'd1);
      tick();
    end
    seed_valid = 1'b0;
  endtask

  task automatic wait_valid16(output int cnt);
    cnt = 0;
    while (v16 !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  // Random in_ready; expected word pushed when a transfer is offered, popped
  // and compared against what the DUT presents for that transfer.
  task automatic stream(input int n, input bit both);
    bit r;
    for (int i = 0; i < n; i++) begin
      r = ($urandom_range(0, 3) != 0);
      ready = r;
      if (r) begin
        q0.push_back(m_out(0)); m_step(0);
        if (both) begin q16.push_back(m_out(1)); m_step(1); end
        check("stream0", r0, q0.pop_front());
        if (both) check("stream16", r16, q16.pop_front());
      end else begin
        check("hold0", r0, m_out(0));
        if (both) check("hold16", r16, m_out(1));
      end
      tick();
    end
    ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] exp_first;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vecs[0] = '{32'd123456789, 32'd362436069, 32'd521288629, 32'd88675123, 32'd3701687786};
    vecs[1] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd3701687786};
    vecs[2] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd2061};
    vecs[3] = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1};
    vecs[4] = '{32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'h000007F8};

    seed = '0; seed_valid = 1'b0; reseed = 1'b0; ready = 1'b0; rst = 1'b1;
    tick();
    check("reset_valid0", {31'd0, v0}, 32'd0);
    check("reset_seed_ready0", {31'd0, sr0}, 32'd1);
    check("reset_random0", r0, 32'd0);
    check("reset_valid16", {31'd0, v16}, 32'd0);
    check("reset_seed_ready16", {31'd0, sr16}, 32'd1);
    check("reset_random16", r16, 32'd0);
    rst = 1'b0;

    // Table: first output without warm-up, and the 17th output after warm-up.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      feed_words(vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].w3, 4);
      check("seed_ready_after_last", {31'd0, sr0}, 32'd0);
      check("valid_after_last", {31'd0, v0}, 32'd1);
      check("first_output", r0, vecs[i].exp_first);
      m_seed(1, vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].w3);
      for (int s = 0; s < 16; s++) m_step(1);
      check("warmup_seed_ready", {31'd0, sr16}, 32'd0);
      wait_valid16(cnt);
      check("warmup_length", 32'(cnt), 32'd16);
      check("warmup_first_output", r16, m_out(1));
      check("hold_without_ready", r0, vecs[i].exp_first);
    end

    // Long stream against the golden model on the default seed.
    do_reset();
    feed_words(vecs[0].w0, vecs[0].w1, vecs[0].w2, vecs[0].w3, 4);
    m_seed(0, vecs[0].w0, vecs[0].w1, vecs[0].w2, vecs[0].w3);
    m_seed(1, vecs[0].w0, vecs[0].w1, vecs[0].w2, vecs[0].w3);
    for (int s = 0; s < 16; s++) m_step(1);
    wait_valid16(cnt);
    check("warmup_length_stream", 32'(cnt), 32'd16);
    stream(1000, 1'b1);

    // Reseed coinciding with a transfer: value delivered, cores frozen.
    ready = 1'b1; reseed = 1'b1;
    check("transfer_on_reseed", r0, m_out(0));
    tick();
    reseed = 1'b0; ready = 1'b0;
    check("reseed_valid0", {31'd0, v0}, 32'd0);
    check("reseed_seed_ready0", {31'd0, sr0}, 32'd1);
    check("reseed_random0", r0, 32'd0);
    check("reseed_valid16", {31'd0, v16}, 32'd0);

    // Reseed on a seed word mid-seed: word dropped, counter restarts.
    feed_words(32'd1, 32'd2, 32'd3, 32'd4, 2);
    seed = 32'd99; seed_valid = 1'b1; reseed = 1'b1;
    tick();
    seed_valid = 1'b0; reseed = 1'b0;
    feed_words(32'd0, 32'd0, 32'd0, 32'h80000000, 4);
    check("reseed_restart_first", r0, 32'h80001000);
    m_seed(0, 32'd0, 32'd0, 32'd0, 32'h80000000);
    stream(50, 1'b0);

    // Reset after two seed words.
    feed_words(32'd5, 32'd6, 32'd7, 32'd8, 0);
    reseed = 1'b1; tick(); reseed = 1'b0;
    feed_words(32'd1, 32'd2, 32'd3, 32'd4, 2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midseed_reset_valid", {31'd0, v0}, 32'd0);
    check("midseed_reset_random", r0, 32'd0);
    check("midseed_reset_seed_ready", {31'd0, sr0}, 32'd1);
    feed_words(32'd1, 32'd2, 32'd3, 32'd4, 3);
    check("three_words_not_enough", {31'd0, v0}, 32'd0);
    seed = 32'd4; seed_valid = 1'b1; tick(); seed_valid = 1'b0;
    check("full_reseed_valid", {31'd0, v0}, 32'd1);
    check("full_reseed_first", r0, 32'd2061);

    // Reset in RUN during a transfer.
    ready = 1'b1; rst = 1'b1; tick(); rst = 1'b0; ready = 1'b0;
    check("midrun_reset_valid", {31'd0, v0}, 32'd0);
    check("midrun_reset_random", r0, 32'd0);
    check("midrun_reset_seed_ready", {31'd0, sr0}, 32'd1);
    feed_words(32'd1, 32'd2, 32'd3, 32'd4, 4);
    check("after_reset_valid", {31'd0, v0}, 32'd1);
    check("after_reset_first", r0, 32'd2061);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xorshift_random_source.md
Name: xorshift_random_source

Overview:
- Randomness producer feeding the masking gadgets: supplies the fresh random words that zero-sharing and refresh blocks consume on their in_random inputs.
- Built from NUM_CORES parallel xorshift128 generators (Marsaglia, 4x32-bit state each).
- Seeded through a word-serial valid/ready port, followed by a configurable warm-up phase.
- Then streams OUT_BITS of randomness per accepted transfer under a valid/ready handshake.

Parameters:
- OUT_BITS, default 2: random bits delivered per transfer. The consumer slices them into its element type, e.g. NUM_NEEDED x bv2_t.
- WARMUP_CYCLES, default 16: generator steps discarded after seeding. 0 is legal.
- NUM_CORES, derived as ceil(OUT_BITS/32), not overridable: number of xorshift128 cores.

Ports:
- in_clock  input  1  clock. All logic on the rising edge.
- in_reset  input  1  reset, synchronous, active-high.
- in_seed  input  32  seed word.
- in_seed_valid  input  1  seed word present.
- out_seed_ready  output  1  block accepts a seed word.
- in_reseed  input  1  single-cycle request to return to seeding.
- out_random  output  OUT_BITS  random data.
- out_valid  output  1  out_random is valid.
- in_ready  input  1  consumer accepts out_random.

Behaviour:
- FSM states: SEED, WARMUP, RUN. A sync reset (in_reset=1 at a clock edge) produces:
  - state=SEED, seed counter=0, warm-up counter=0, all core state registers=0;
  - out_valid=0, out_seed_ready=1, out_random=0 (masked while not RUN).
- Xorshift step for each core, state (x,y,z,w):
  - t = x ^ (x<<11);
  - x'=y, y'=z, z'=w;
  - w' = w ^ (w>>19) ^ t ^ (t>>8).
  - All shifts are 32-bit logical, truncated.
- out_random = low OUT_BITS of {w'[NUM_CORES-1],...,w'[0]}.
  - w' is combinational from the state registers only; no input feeds out_random.
  - It is gated to 0 whenever out_valid=0.
- SEED:
  - out_seed_ready=1. A word is accepted on each cycle with in_seed_valid=1.
  - Word index k loads core k/4, register k%4 (0=x, 1=y, 2=z, 3=w). The counter runs 0..4*NUM_CORES-1.
  - On acceptance of the last word, if any core's four registers are all zero, that core instead loads the defaults x=123456789, y=362436069, z=521288629, w=88675123.
  - Next state is WARMUP if WARMUP_CYCLES>0, else RUN (taking effect next cycle).
- WARMUP:
  - out_seed_ready=0, out_valid=0.
  - All cores step every cycle.
  - After exactly WARMUP_CYCLES steps, go to RUN.
- RUN:
  - out_valid=1.
  - On a cycle with out_valid and in_ready both 1, all cores step and the next cycle presents a new value.
  - With in_ready=0, out_random holds stable.
- in_reseed=1 in any state:
  - next state SEED, seed counter=0, warm-up counter=0;
  - out_valid falls on the next cycle;
  - core state is retained until overwritten.
  - If it coincides with a RUN transfer, the transfer completes (the consumer keeps the value) but the cores do not step.
  - If it coincides with a seed word in SEED, the word is discarded and the counter restarts at 0.
- Partial seeding is held indefinitely: no timeout.
- in_reset has priority over in_reseed and all handshakes.

Decomposition:
- Shared package aes128_package gets:
  - XS_SEED_X/Y/Z/W constants;
  - xs_state_t, a packed struct of four 32-bit words;
  - rs_state_e, the FSM enum.
- Sub-module xorshift128_core:
  - ports in_clock, in_reset, in_load, in_load_idx[1:0], in_load_word, in_step, out_next_w;
  - holds one xs_state_t and implements the step function.
- Top level contains the FSM, the counters, the zero-seed fix and output gating.

Test Plan:
- Reset, then feed seed words 123456789, 362436069, 521288629, 88675123 with OUT_BITS=32 and WARMUP_CYCLES=0, in_ready=0.
  - out_seed_ready falls after word 4; out_valid=1 on the next cycle.
  - out_random=3701687786 and holds while in_ready=0.
- Same setup, then in_ready=1 for 1000 cycles: out_random matches a C xorshift128 golden model each cycle.
- Four all-zero seed words, WARMUP_CYCLES=0: sequence is identical to the default-seed scenario, starting at 3701687786.
- WARMUP_CYCLES=16, default seed:
  - out_valid stays 0 for exactly 16 cycles after the last seed word;
  - first valid out_random equals the golden model's 17th output.
- In RUN, pulse in_reseed together with in_ready=1:
  - out_valid=0 the next cycle, out_seed_ready=1;
  - reseeding with new words restarts the golden sequence from those words.
- Assert in_reset mid-seed (after 2 words) and mid-RUN:
  - next cycle out_valid=0, out_random=0, out_seed_ready=1;
  - a full 4-word reseed is then required before out_valid=1.
